mem_bus_arbiter: RTL and testbench

//  Shares one single-port memory bus between instruction fetch (I) and load/store (D).

---
 rtl/mem_bus_arbiter_pkg.sv | 22 ++
 rtl/mem_bus_arbiter_pick.sv | 49 ++++
 rtl/mem_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
// Holds the FSM state codes, the bus owner codes and a width helper
// for the D-streak counter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Bits needed to count 0..max inclusive.
    function automatic int streak_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Purpose : grant decision between fetch (I) and load/store (D), plus the D-streak counter.
// Latency : picks are combinational; the streak counter updates on the grant edge.
// Backpress: no pick unless enabled (arbiter idle); a pending I caps D at MAX_D_STREAK grants.
// Ports   : clk/rst; en = arbiter idle; i_req/i_kill/d_req requests; pick_d/pick_i one-hot grant.
module mem_bus_arbiter_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic i_req,
    input  logic i_kill,
    input  logic d_req,
    output logic pick_d,
    output logic pick_i
);

    localparam int SW = streak_w(MAX_D_STREAK);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak;
    logic          i_starved;

    // D normally wins; once it has taken MAX_D_STREAK grants in a row while
    // I was waiting, the next decision goes to I. A killed I blocks its own
    // grant but still counts as pending for the starvation test.
    always_comb begin
        i_starved = i_req && (streak == STREAK_MAX);
        pick_d    = en && d_req && !i_starved;
        pick_i    = en && !pick_d && i_req && !i_kill;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (pick_d) begin
            if (!i_req) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + SW'(1);
            end
        end else if (pick_i) begin
            streak <= '0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Purpose : shares one single-port memory bus between fetch (I) and load/store (D), one transaction at a time.
// Latency : request at n -> bus_req at n+1 -> (gnt n+1, rvalid n+2) -> x_rvalid pulse at n+3.
// Backpress: bus_req held until bus_gnt; requesters see if_stall/mem_stall until their rvalid pulse.
// Ports   : clk, rst (async, active high); i_* fetch side; d_* load/store side; if_stall/mem_stall
//           to the hazard unit; bus_* request fields out, bus_gnt/bus_rvalid/bus_rdata in.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_kill,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                if_stall,
    output logic                mem_stall,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata
);

    state_t state;
    state_t state_next;
    owner_t owner;
    logic   kill_pend;
    logic   pick_d;
    logic   pick_i;
    logic   resp_done;
    logic   bus_req_next;
    logic   i_killed;

    mem_bus_arbiter_pick #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_pick (
        .clk    (clk),
        .rst    (rst),
        .en     (state == ST_IDLE),
        .i_req  (i_req),
        .i_kill (i_kill),
        .d_req  (d_req),
        .pick_d (pick_d),
        .pick_i (pick_i)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. REQ never returns to IDLE without a grant, so a
    // kill cannot strand a half-issued bus request.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (pick_d || pick_i) state_next = ST_REQ;
            ST_REQ:  if (bus_gnt)          state_next = ST_RESP;
            ST_RESP: if (bus_rvalid)       state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    // FSM outputs. bus_req is flopped from the next state so it rises the
    // cycle after a pick and falls the cycle after the grant.
    always_comb begin
        resp_done    = (state == ST_RESP) && bus_rvalid;
        bus_req_next = (state_next == ST_REQ);
        // A kill arriving in the very cycle the response lands also counts.
        i_killed     = kill_pend || i_kill;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            owner     <= OWN_I;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
        end else begin
            bus_req <= bus_req_next;
            if (pick_d) begin
                owner     <= OWN_D;
                bus_we    <= d_we;
                bus_addr  <= d_addr;
                bus_wdata <= d_we ? d_wdata : '0;
                bus_wstrb <= d_we ? d_wstrb : '0;
            end else if (pick_i) begin
                owner     <= OWN_I;
                bus_we    <= 1'b0;
                bus_addr  <= i_addr;
                bus_wdata <= '0;
                bus_wstrb <= '0;
            end
        end
    end

    // A killed fetch still runs to completion on the bus; only its
    // delivery to the fetch stage is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kill_pend <= 1'b0;
        end else if (state_next == ST_IDLE) begin
            kill_pend <= 1'b0;
        end else if ((state != ST_IDLE) && (owner == OWN_I) && i_kill) begin
            kill_pend <= 1'b1;
        end
    end

    // Response routing: each owner's rdata only moves on its own completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (resp_done && (owner == OWN_I) && !i_killed) begin
                i_rvalid <= 1'b1;
                i_rdata  <= bus_rdata;
            end
            if (resp_done && (owner == OWN_D)) begin
                d_rvalid <= 1'b1;
                d_rdata  <= bus_we ? '0 : bus_rdata;
            end
        end
    end

    // Stalls are combinational so the hazard unit releases in the same
    // cycle the data arrives; forced low while reset is held.
    always_comb begin
        if_stall  = !rst && i_req && !i_rvalid;
        mem_stall = !rst && d_req && !d_rvalid;
    end

    a_rvalid_in_resp: assert property (@(posedge clk) disable iff (rst)
        bus_rvalid |-> (state == ST_RESP));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_kill, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        if_stall, mem_stall;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    // Bus side: either driven directly by the test, or an automatic
    // responder that grants immediately and answers one cycle later with ~addr.
    logic        auto_mode = 1'b0;
    logic        man_gnt, man_rvalid;
    logic [31:0] man_rdata;
    logic        resp_pend = 1'b0;
    logic [31:0] auto_rdata = '0;

    assign bus_gnt    = auto_mode ? bus_req : man_gnt;
    assign bus_rvalid = auto_mode ? resp_pend : man_rvalid;
    assign bus_rdata  = auto_mode ? auto_rdata : man_rdata;

    always @(posedge clk) begin
        resp_pend <= auto_mode && bus_req && bus_gnt;
        if (bus_req && bus_gnt) auto_rdata <= ~bus_addr;
    end

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_kill     (i_kill),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .if_stall   (if_stall),
        .mem_stall  (mem_stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " i_rvalid"},  {31'b0, i_rvalid},  32'h0);
        chk({tag, " i_rdata"},   i_rdata,            32'h0);
        chk({tag, " d_rvalid"},  {31'b0, d_rvalid},  32'h0);
        chk({tag, " d_rdata"},   d_rdata,            32'h0);
        chk({tag, " if_stall"},  {31'b0, if_stall},  32'h0);
        chk({tag, " mem_stall"}, {31'b0, mem_stall}, 32'h0);
        chk({tag, " bus_req"},   {31'b0, bus_req},   32'h0);
        chk({tag, " bus_we"},    {31'b0, bus_we},    32'h0);
        chk({tag, " bus_addr"},  bus_addr,           32'h0);
        chk({tag, " bus_wdata"}, bus_wdata,          32'h0);
        chk({tag, " bus_wstrb"}, {28'b0, bus_wstrb}, 32'h0);
    endtask

    // One row = inputs for a cycle plus the outputs expected mid-cycle
    // (registered outputs reflect the previous edge).
    typedef struct {
        logic        i_req;
        logic        i_kill;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_irv;
        logic [31:0] e_irdata;
        logic        e_drv;
        logic [31:0] e_drdata;
        logic        e_ifst;
        logic        e_memst;
        logic        e_breq;
        logic [31:0] e_baddr;
    } vec_t;

    vec_t tv[13];

    initial begin
        logic [31:0] got[$];
        logic [31:0] exp_order[10];
        int          cyc;
        int          nd;
        int          d_cyc[3];
        logic [31:0] d_dat[3];
        int          lat;

        // Fetch, killed fetch, D load, kill-in-IDLE blocking.
        //          ireq kill iaddr        dreq we daddr        gnt rv rdata          irv irdata        drv drdata        ifst mst breq baddr
        tv[0]  = '{1'b1,1'b0,32'h100,     1'b0,1'b0,32'h0,    1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0};
        tv[1]  = '{1'b1,1'b0,32'h100,     1'b0,1'b0,32'h0,    1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b1,32'h100};
        tv[2]  = '{1'b1,1'b0,32'h100,     1'b0,1'b0,32'h0,    1'b1,1'b1,32'h12345678, 1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b0,32'h100};
        tv[3]  = '{1'b1,1'b0,32'h104,     1'b0,1'b0,32'h0,    1'b1,1'b0,32'h0,        1'b1,32'h12345678, 1'b0,32'h0,        1'b0,1'b0,1'b0,32'h100};
        tv[4]  = '{1'b1,1'b1,32'h104,     1'b0,1'b0,32'h0,    1'b1,1'b0,32'h0,        1'b0,32'h12345678, 1'b0,32'h0,        1'b1,1'b0,1'b1,32'h104};
        tv[5]  = '{1'b0,1'b0,32'h104,     1'b0,1'b0,32'h0,    1'b1,1'b1,32'hBAD00BAD, 1'b0,32'h12345678, 1'b0,32'h0,        1'b0,1'b0,1'b0,32'h104};
        tv[6]  = '{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,    1'b1,1'b0,32'h0,        1'b0,32'h12345678, 1'b0,32'h0,        1'b0,1'b0,1'b0,32'h104};
        tv[7]  = '{1'b0,1'b0,32'h0,       1'b1,1'b0,32'h200,  1'b1,1'b0,32'h0,        1'b0,32'h12345678, 1'b0,32'h0,        1'b0,1'b1,1'b0,32'h104};
        tv[8]  = '{1'b0,1'b0,32'h0,       1'b1,1'b0,32'h200,  1'b1,1'b0,32'h0,        1'b0,32'h12345678, 1'b0,32'h0,        1'b0,1'b1,1'b1,32'h200};
        tv[9]  = '{1'b0,1'b0,32'h0,       1'b1,1'b0,32'h200,  1'b1,1'b1,32'hCAFEF00D, 1'b0,32'h12345678, 1'b0,32'h0,        1'b0,1'b1,1'b0,32'h200};
        tv[10] = '{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h200,  1'b1,1'b0,32'h0,        1'b0,32'h12345678, 1'b1,32'hCAFEF00D, 1'b0,1'b0,1'b0,32'h200};
        tv[11] = '{1'b1,1'b1,32'h300,     1'b0,1'b0,32'h0,    1'b1,1'b0,32'h0,        1'b0,32'h12345678, 1'b0,32'hCAFEF00D, 1'b1,1'b0,1'b0,32'h200};
        tv[12] = '{1'b0,1'b0,32'h300,     1'b0,1'b0,32'h0,    1'b1,1'b0,32'h0,        1'b0,32'h12345678, 1'b0,32'hCAFEF00D, 1'b0,1'b0,1'b0,32'h200};

        rst = 1'b0;
        i_req = 1'b0; i_kill = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;

        // Reset state.
        #1 rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Table-driven cycles.
        for (int k = 0; k < 13; k++) begin
            i_req = tv[k].i_req; i_kill = tv[k].i_kill; i_addr = tv[k].i_addr;
            d_req = tv[k].d_req; d_we = tv[k].d_we; d_addr = tv[k].d_addr;
            man_gnt = tv[k].gnt; man_rvalid = tv[k].rv; man_rdata = tv[k].rdata;
            #1;
            chk($sformatf("row%0d i_rvalid", k),  {31'b0, i_rvalid},  {31'b0, tv[k].e_irv});
            chk($sformatf("row%0d i_rdata", k),   i_rdata,            tv[k].e_irdata);
            chk($sformatf("row%0d d_rvalid", k),  {31'b0, d_rvalid},  {31'b0, tv[k].e_drv});
            chk($sformatf("row%0d d_rdata", k),   d_rdata,            tv[k].e_drdata);
            chk($sformatf("row%0d if_stall", k),  {31'b0, if_stall},  {31'b0, tv[k].e_ifst});
            chk($sformatf("row%0d mem_stall", k), {31'b0, mem_stall}, {31'b0, tv[k].e_memst});
            chk($sformatf("row%0d bus_req", k),   {31'b0, bus_req},   {31'b0, tv[k].e_breq});
            chk($sformatf("row%0d bus_addr", k),  bus_addr,           tv[k].e_baddr);
            tick();
        end
        i_req = 1'b0; i_kill = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0;

        // Streak limit: I and D both held, expect D,D,D,D,I,D,D,D,D,I.
        auto_mode = 1'b1;
        i_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 10; k++) exp_order[k] = ((k % 5) == 4) ? 32'h1000 : 32'h2000;
        begin
            logic prev_req;
            prev_req = bus_req;
            cyc = 0;
            while (got.size() < 10 && cyc < 80) begin
                tick();
                cyc++;
                if (bus_req && !prev_req) got.push_back(bus_addr);
                prev_req = bus_req;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("streak grant count", got.size(), 32'd10);
        for (int k = 0; k < 10 && k < got.size(); k++)
            chk($sformatf("streak grant %0d", k), got[k], exp_order[k]);
        repeat (6) tick();

        // Store with grant held off for 3 cycles; fields must stay latched.
        auto_mode = 1'b0;
        man_gnt = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_wstrb = 4'h3;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("store c%0d bus_req", c),   {31'b0, bus_req},   32'h1);
            chk($sformatf("store c%0d bus_we", c),    {31'b0, bus_we},    32'h1);
            chk($sformatf("store c%0d bus_addr", c),  bus_addr,           32'h40);
            chk($sformatf("store c%0d bus_wdata", c), bus_wdata,          32'hDEADBEEF);
            chk($sformatf("store c%0d bus_wstrb", c), {28'b0, bus_wstrb}, 32'h3);
            d_wdata = 32'h0;
            if (c == 2) man_gnt = 1'b1;
            tick();
        end
        man_gnt = 1'b0;
        chk("store bus_req dropped", {31'b0, bus_req}, 32'h0);
        man_rvalid = 1'b1; man_rdata = 32'h55555555;
        tick();
        man_rvalid = 1'b0;
        chk("store d_rvalid",  {31'b0, d_rvalid},  32'h1);
        chk("store d_rdata",   d_rdata,            32'h0);
        chk("store mem_stall", {31'b0, mem_stall}, 32'h0);
        d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
        tick();
        chk("store pulse width", {31'b0, d_rvalid}, 32'h0);

        // Back-to-back loads to 0x0, 0x4, 0x8: pulses 3 cycles apart.
        auto_mode = 1'b1;
        d_req = 1'b1; d_addr = 32'h0;
        nd = 0; cyc = 0;
        while (nd < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (d_rvalid) begin
                d_cyc[nd] = cyc;
                d_dat[nd] = d_rdata;
                nd++;
                if (nd < 3) d_addr = 32'(nd * 4);
                else d_req = 1'b0;
            end
        end
        d_req = 1'b0;
        chk("b2b pulse count", nd, 32'd3);
        if (nd == 3) begin
            chk("b2b first latency", d_cyc[0], 32'd3);
            chk("b2b gap 1", d_cyc[1] - d_cyc[0], 32'd3);
            chk("b2b gap 2", d_cyc[2] - d_cyc[1], 32'd3);
            chk("b2b data 0", d_dat[0], 32'hFFFFFFFF);
            chk("b2b data 1", d_dat[1], 32'hFFFFFFFB);
            chk("b2b data 2", d_dat[2], 32'hFFFFFFF7);
        end
        repeat (3) tick();

        // Reset while in RESP, then a fresh fetch completes normally.
        auto_mode = 1'b0;
        man_gnt = 1'b1;
        i_req = 1'b1; i_addr = 32'h500;
        tick();
        tick();
        i_req = 1'b0; man_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("rst in RESP");
        tick();
        rst = 1'b0;
        tick();
        auto_mode = 1'b1;
        i_req = 1'b1; i_addr = 32'h600;
        lat = 0;
        while (!i_rvalid && lat < 20) begin
            tick();
            lat++;
        end
        i_req = 1'b0;
        chk("post-reset fetch latency", lat, 32'd3);
        chk("post-reset fetch data", i_rdata, ~32'h600);
        chk("post-reset d_rvalid", {31'b0, d_rvalid}, 32'h0);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
